// File: rtl/hc595_chain_rx.sv
`default_nettype none
// ============================================================================
//  Module      : hc595_chain_rx
//  Description : Receive-side decoder for a six-lane 74HC595 LED drive bus.
//                It synchronizes shcp/stcp/ds0..ds5 into clk and shifts each
//                lane into a per-lane shift register on shcp rises. On stcp
//                rises it latches the shift registers into the LED vector.
//                Optional feature macro: HC595_RX_BITCHK_EN. When it is
//                defined, the shift count per latch is checked against
//                LANE_BITS.
//  Revision    : 1.0 - initial release
// ============================================================================
module hc595_chain_rx #(
  parameter int LANE_BITS   = 8,
  parameter int LED_NUM     = 40,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               shcp,
  input  logic               stcp,
  input  logic               ds0,
  input  logic               ds1,
  input  logic               ds2,
  input  logic               ds3,
  input  logic               ds4,
  input  logic               ds5,
  output logic [LED_NUM-1:0] led_state,
  output logic               led_valid,
  output logic [15:0]        frame_cnt,
  output logic               err_bitcnt
);

  localparam int c_lanes = 6;
  localparam int c_bus_w = c_lanes + 2;
  localparam int c_sr_w  = c_lanes * LANE_BITS;
  localparam int c_arm_w = $clog2(SYNC_STAGES + 2);
  localparam logic [c_arm_w-1:0] c_arm_done = c_arm_w'(SYNC_STAGES + 1);

  // Bus bundle: data lanes in the low bits, strobes on top, so all eight
  // inputs travel through one identical synchronizer chain.
  logic [c_bus_w-1:0] w_bus;
  assign w_bus = {stcp, shcp, ds5, ds4, ds3, ds2, ds1, ds0};

  logic [c_bus_w-1:0] r_sync [SYNC_STAGES];
  logic [c_bus_w-1:0] w_sync;
  logic [c_lanes-1:0] w_ds_sync;
  logic               w_shcp_sync;
  logic               w_stcp_sync;

  // Synchronizer chain for the whole bus.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_sync[0] <= w_bus;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign w_sync      = r_sync[SYNC_STAGES-1];
  assign w_ds_sync   = w_sync[c_lanes-1:0];
  assign w_shcp_sync = w_sync[c_lanes];
  assign w_stcp_sync = w_sync[c_lanes+1];

  logic [c_arm_w-1:0] r_arm_cnt;
  logic               w_armed;

  // Arming counter: edges are ignored until the sync chain and the previous
  // value flops hold real bus state, so a bus already high at reset release
  // is not mistaken for a rise.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_arm_cnt <= '0;
    end else if (r_arm_cnt != c_arm_done) begin
      r_arm_cnt <= r_arm_cnt + 1'b1;
    end
  end

  assign w_armed = (r_arm_cnt == c_arm_done);

  logic               r_shcp_prev;
  logic               r_stcp_prev;
  logic               r_shcp_rise;
  logic               r_stcp_rise;
  logic [c_lanes-1:0] r_ds_d;

  // Rise detection; data is delayed alongside so it stays aligned with the
  // registered shcp rise.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_shcp_prev <= 1'b0;
      r_stcp_prev <= 1'b0;
      r_shcp_rise <= 1'b0;
      r_stcp_rise <= 1'b0;
      r_ds_d      <= '0;
    end else begin
      r_shcp_prev <= w_shcp_sync;
      r_stcp_prev <= w_stcp_sync;
      r_shcp_rise <= w_armed & w_shcp_sync & ~r_shcp_prev;
      r_stcp_rise <= w_armed & w_stcp_sync & ~r_stcp_prev;
      r_ds_d      <= w_ds_sync;
    end
  end

  logic [LANE_BITS-1:0] r_sr [c_lanes];
  logic [c_sr_w-1:0]    w_sr_flat;

  // Per-lane shift registers, MSB-first: the first bit shifted ends at the top.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < c_lanes; k++) begin
        r_sr[k] <= '0;
      end
    end else if (r_shcp_rise) begin
      for (int k = 0; k < c_lanes; k++) begin
        r_sr[k] <= {r_sr[k][LANE_BITS-2:0], r_ds_d[k]};
      end
    end
  end

  for (genvar k = 0; k < c_lanes; k++) begin : g_sr_flat
    assign w_sr_flat[k*LANE_BITS +: LANE_BITS] = r_sr[k];
  end

  // Bits beyond LED_NUM are never latched.
  logic w_unused_sr;
  assign w_unused_sr = ^w_sr_flat;

  logic [LED_NUM-1:0] r_led;
  logic               r_valid;
  logic [15:0]        r_frame_cnt;

  // Storage register: a same-cycle shift and latch sees the pre-shift
  // content, exactly as the 74HC595 does.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_led       <= '0;
      r_valid     <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_valid <= r_stcp_rise;
      if (r_stcp_rise) begin
        r_led       <= w_sr_flat[LED_NUM-1:0];
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  assign led_state = r_led;
  assign led_valid = r_valid;
  assign frame_cnt = r_frame_cnt;

`ifdef HC595_RX_BITCHK_EN
  localparam logic [7:0] c_lane_bits = 8'(LANE_BITS);

  logic [7:0] r_shift_cnt;
  logic       r_err;

  // Shift counter since the last latch; a coincident shift is the first bit
  // of the next frame, so the count restarts at 1.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_shift_cnt <= '0;
      r_err       <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (r_stcp_rise) begin
        r_err       <= (r_shift_cnt != c_lane_bits);
        r_shift_cnt <= r_shcp_rise ? 8'd1 : 8'd0;
      end else if (r_shcp_rise && (r_shift_cnt != 8'hFF)) begin
        r_shift_cnt <= r_shift_cnt + 8'd1;
      end
    end
  end

  assign err_bitcnt = r_err;
`else
  assign err_bitcnt = 1'b0;
`endif

endmodule
`default_nettype wire
